mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words; the word index is addr[7:2].
REQ-002 The block SHALL have parameter WAIT, default 2, meaning cycles between request acceptance and response valid; legal range 1..15.

Ports:
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_we  input  1  1 = store word, 0 = load word.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  initiator consumes the response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-014 A request SHALL be accepted on a cycle with req_valid && req_ready.
- On acceptance, req_we, req_addr and req_wdata are captured into internal registers.
- Inputs on other cycles are ignored.
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
- IDLE -> BUSY on acceptance.
- BUSY -> RESP when the wait counter reaches 0.
- RESP -> IDLE on rsp_ready.
REQ-016 req_ready SHALL be 1 only in IDLE.
- No second request is accepted until the current response is consumed.
REQ-017 On acceptance, the wait counter SHALL load WAIT-1 and decrement once per BUSY cycle.
- rsp_valid rises exactly WAIT cycles after the acceptance edge.
REQ-018 rsp_valid SHALL be 1 only in RESP.
- rsp_rdata and rsp_err stay stable while rsp_valid && !rsp_ready.
REQ-019 rsp_err SHALL be 1 when the captured addr[1:0] != 0 or addr[31:2] >= DEPTH.
- An erroring store leaves memory unmodified.
- An erroring load returns rsp_rdata = 0.
REQ-020 A valid store SHALL write mem[addr[7:2]] on the BUSY->RESP transition edge.
REQ-021 A valid load SHALL latch mem[addr[7:2]] into rsp_rdata on the BUSY->RESP edge.
- A store immediately following returns a consistent read-after-write.
REQ-022 Storage SHALL be DEPTH x 32 bits with synchronous write and a single access port.
REQ-023 rsp_ready asserted outside RESP SHALL have no effect.
REQ-024 Words never written SHALL read as 0.

Reset
REQ-025 When reset is 1 at a clk edge:
- state = IDLE, wait counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- req_ready = 1 from the following cycle.
REQ-026 Reset asserted in BUSY or RESP SHALL abort the request without writing memory and drop rsp_valid at that edge.
REQ-027 Reset SHALL clear every memory word to 0.
- A reset-walk is permitted only if req_ready stays 0 until it completes.
- Default implementation: a parallel clear.

Structure
REQ-028 A shared package mem_pkg SHALL hold:
- the state enum type mem_state_t {IDLE, BUSY, RESP};
- the constant WORD_BYTES = 4;
- the default DEPTH and WAIT values.
REQ-029 Storage SHALL be a sub-module word_ram (ports clk, reset, we, addr, wdata, rdata).
- The FSM, counter and error check live in mem_responder.

Verification
REQ-030 Basic write then read:
- Store 0xDEADBEEF to 0x10 with rsp_ready held 1 -> rsp_valid high exactly 2 cycles after acceptance, rsp_err = 0.
- Then load 0x10 -> rsp_rdata = 0xDEADBEEF.
REQ-031 Misaligned access:
- Store 0x12345678 to 0x13 -> rsp_err = 1.
- Load 0x10 -> still 0xDEADBEEF.
REQ-032 Out-of-range load: load 0x100 (DEPTH = 64) -> rsp_err = 1, rsp_rdata = 0.
REQ-033 Back-pressure:
- Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable; req_ready = 0 throughout.
- Release rsp_ready -> req_ready = 1 on the next cycle.
REQ-034 Reset mid-operation:
- Accept a store of 0xA5A5A5A5 to 0x20, assert reset in BUSY -> rsp_valid never rises.
- Subsequent load 0x20 -> 0.
REQ-035 Latency sweep: WAIT = 1 and WAIT = 15 -> rsp_valid rises exactly WAIT cycles after acceptance, checked by an assertion on every transaction.

Source files
------------

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory responder slice:
//   - mem_state_t : responder FSM state encoding (IDLE, BUSY, RESP)
//   - WORD_BYTES  : bytes per storage word
//   - DEFAULT_DEPTH / DEFAULT_WAIT : default parameter values
//   - addr_err_f  : misalignment / range check on a byte address
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int WORD_BYTES    = 4;
    localparam int DEFAULT_DEPTH = 64;
    localparam int DEFAULT_WAIT  = 2;

    // A byte address is in error when it is not word aligned or when its
    // word index lands at or beyond the configured number of words.
    function automatic logic addr_err_f(input logic [31:0] addr, input logic [31:0] depth);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/word_ram.sv
// ---------------------------------------------------------------------------
// word_ram
// DEPTH x 32-bit single-port storage. Synchronous write, combinational read
// of the same address. Reset clears every word in parallel so that words
// never written read back as zero.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high clear of all words
//   we    : write enable
//   addr  : word index
//   wdata : write data
//   rdata : contents of mem[addr]
// ---------------------------------------------------------------------------
module word_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];

    // Parallel clear on reset, otherwise single-word write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Valid/ready memory target. A request is captured when req_valid && req_ready,
// the responder then waits WAIT cycles, performs the store or load on the
// edge that enters RESP, and holds the response until rsp_ready.
// Parameters:
//   DEPTH : number of 32-bit words (word index is addr[7:2] for 64)
//   WAIT  : cycles from acceptance to rsp_valid, 1..15
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_we              : 1 = store, 0 = load
//   req_addr/req_wdata  : byte address and store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data, 0 for stores and errors
//   rsp_err             : misaligned or out-of-range request
// ---------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WAIT  = DEFAULT_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT - 1);

    mem_state_t  state_r;
    logic [3:0]  wait_cnt_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic        err_s;
    logic        finish_s;
    logic        ram_we_s;
    logic [31:0] ram_rdata_s;

    // Error status and the BUSY->RESP edge are derived from captured state only.
    always_comb begin
        err_s    = addr_err_f(addr_r, DEPTH_W);
        finish_s = (state_r == BUSY) && (wait_cnt_r == 4'd0);
        ram_we_s = finish_s && we_r && !err_s;
    end

    word_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_word_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we_s),
        .addr  (addr_r[2 +: AW]),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    // Responder FSM with request capture, wait counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 4'd0;
            we_r        <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready_r) begin
                        we_r        <= req_we;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        wait_cnt_r  <= WAIT_LOAD;
                        req_ready_r <= 1'b0;
                        state_r     <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish_s) begin
                        // Memory write (if any) happens on this same edge via ram_we_s.
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= err_s;
                        rsp_rdata_r <= (!we_r && !err_s) ? ram_rdata_s : 32'd0;
                        state_r     <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    wait_cnt_r  <= 4'd0;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_valid_a [3];
    logic        req_ready_a [3];
    logic        rsp_valid_a [3];
    logic        rsp_ready_a [3];
    logic [31:0] rsp_rdata_a [3];
    logic        rsp_err_a   [3];

    int wait_of [3];
    logic [31:0] model_mem [3][64];

    int checks;
    int errors;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    mem_responder #(.DEPTH(64), .WAIT(2)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready_a[0]),
        .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_a[0])
    );

    mem_responder #(.DEPTH(64), .WAIT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready_a[1]),
        .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_a[1])
    );

    mem_responder #(.DEPTH(64), .WAIT(15)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a[2]), .rsp_ready(rsp_ready_a[2]),
        .rsp_rdata(rsp_rdata_a[2]), .rsp_err(rsp_err_a[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference rule: misaligned, or word index beyond 64 words.
    function automatic logic model_err(input logic [31:0] addr);
        return (addr % 32'd4 != 32'd0) || ((addr / 32'd4) >= 32'd64);
    endfunction

    function automatic logic [31:0] model_rdata(input int idx, input logic we, input logic [31:0] addr);
        if (we || model_err(addr)) return 32'd0;
        return model_mem[idx][int'(addr / 32'd4)];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 64; w++)
                model_mem[i][w] = 32'd0;
    endtask

    task automatic txn(input int idx, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold,
                       input logic exp_err, input logic [31:0] exp_rdata, input string tag);
        int n;
        int lat;
        int bad;
        logic [31:0] s_rdata;
        logic        s_err;
        @(negedge clk);
        req_we           = we;
        req_addr         = addr;
        req_wdata        = wdata;
        req_valid_a[idx] = 1'b1;
        rsp_ready_a[idx] = (hold == 0);
        n = 0;
        while (!req_ready_a[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_a[idx]) begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid_a[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble request inputs: they must be ignored after acceptance.
        req_valid_a[idx] = 1'b0;
        req_we           = 1'($urandom);
        req_addr         = $urandom;
        req_wdata        = $urandom;
        chk({tag, "_ready_busy"}, {31'd0, req_ready_a[idx]}, 32'd0);
        lat = 0;
        while (!rsp_valid_a[idx] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(wait_of[idx]));
        if (!rsp_valid_a[idx]) return;
        chk({tag, "_err"}, {31'd0, rsp_err_a[idx]}, {31'd0, exp_err});
        chk({tag, "_rdata"}, rsp_rdata_a[idx], exp_rdata);
        s_rdata = rsp_rdata_a[idx];
        s_err   = rsp_err_a[idx];
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid_a[idx] !== 1'b1 || rsp_rdata_a[idx] !== s_rdata ||
                rsp_err_a[idx] !== s_err || req_ready_a[idx] !== 1'b0) bad++;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 32'(bad), 32'd0);
        rsp_ready_a[idx] = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, {30'd0, rsp_valid_a[idx], req_ready_a[idx]}, 32'd1);
        if (we && !model_err(addr)) model_mem[idx][int'(addr / 32'd4)] = wdata;
        // Stray rsp_ready outside RESP must be harmless.
        rsp_ready_a[idx] = 1'($urandom);
    endtask

    initial begin
        int bad;
        int n;
        logic        r_we;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        int          r_hold;
        int          sel;

        checks = 0;
        errors = 0;
        wait_of[0] = 2;
        wait_of[1] = 1;
        wait_of[2] = 15;
        clear_model();

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 0, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0013, 32'h1234_5678, 0, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 0, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 0, 1'b1, 32'h0000_0000};
        vecs[5] = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 0, 1'b0, 32'h0000_0000};
        vecs[6] = '{1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 5, 1'b0, 32'h0000_0000};
        vecs[7] = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 5, 1'b0, 32'h0BAD_F00D};
        vecs[8] = '{1'b0, 32'h0000_0102, 32'h0000_0000, 0, 1'b1, 32'h0000_0000};
        vecs[9] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 32'h0000_0000};

        reset     = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            req_valid_a[i] = 1'b0;
            rsp_ready_a[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_state%0d", i),
                {rsp_rdata_a[i][29:0], req_ready_a[i], rsp_valid_a[i]} | {31'd0, rsp_err_a[i]},
                32'd2);
        end

        for (int v = 0; v < 10; v++) begin
            txn(0, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].hold,
                vecs[v].exp_err, vecs[v].exp_rdata, $sformatf("vec%0d", v));
        end
        chk("vec_upper_rdata_bits", {30'd0, rsp_rdata_a[0][31:30]}, 32'd0);

        // Reset while BUSY: abort, no write, rsp_valid never rises.
        @(negedge clk);
        req_we         = 1'b1;
        req_addr       = 32'h0000_0020;
        req_wdata      = 32'hA5A5_A5A5;
        req_valid_a[0] = 1'b1;
        rsp_ready_a[0] = 1'b1;
        n = 0;
        while (!req_ready_a[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_accept", {31'd0, req_ready_a[0]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid_a[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        chk("midreset_ready", {31'd0, req_ready_a[0]}, 32'd1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid_a[0] !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("midreset_no_rsp", 32'(bad), 32'd0);
        txn(0, 1'b0, 32'h0000_0020, 32'd0, 0, 1'b0, 32'd0, "midreset_load");

        // Randomized traffic on each latency variant against the reference model.
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 30; t++) begin
                r_we    = 1'($urandom);
                sel     = int'($urandom_range(0, 9));
                if (sel < 7)      r_addr = 32'($urandom_range(0, 15)) * 32'd4;
                else if (sel < 8) r_addr = $urandom_range(0, 255);
                else              r_addr = $urandom;
                r_wdata = $urandom;
                r_hold  = int'($urandom_range(0, 3));
                txn(i, r_we, r_addr, r_wdata, r_hold, model_err(r_addr),
                    model_rdata(i, r_we, r_addr), $sformatf("rnd%0d_%0d", i, t));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
